imem_load_ctrl: RTL
===================

Name: imem_load_ctrl

Overview:
Sequences writes into the 4096-word instruction memory. Loads a program image arriving as a UART byte stream: a 4-byte word count followed by that many 32-bit words, written from word address BASE_ADDR upward. While loading, the core is held in stall. Outside loads, it arbitrates the single imem write port between the loader and core stores to the instruction-memory window.

Parameters:
ADDR_W, 12, imem word-address width (4096 words)
BASE_ADDR, 0, first word address written by a load
MAX_WORDS, 4068, largest accepted word count; words at 4068..4095 hold the resident boot loader and are never overwritten by a load

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a load; ignored unless state is IDLE, DONE or ERR
rx_valid  in  1  UART byte available
rx_data  in  8  UART byte
rx_ready  out  1  byte consumed this cycle when rx_valid && rx_ready
st_req  in  1  core store request to the imem window
st_addr  in  ADDR_W  core store word address
st_data  in  32  core store data
st_gnt  out  1  core store accepted this cycle
wr_en  out  1  imem write enable
wr_addr  out  ADDR_W  imem write word address
wr_data  out  32  imem write data
core_stall  out  1  1 = core pipeline frozen (drives n_stall low)
busy  out  1  state is LEN or DATA
done  out  1  one-cycle pulse after the last word is written
err  out  1  level; count exceeded MAX_WORDS
words_loaded  out  ADDR_W+1  words written by the current or last load

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0: wr_*, st_gnt, done, err, busy, core_stall, rx_ready, words_loaded. Byte and word counters also 0.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE/DONE/ERR: rx_ready=0. start -> LEN; clears err, words_loaded and byte_cnt; core_stall=1 from the next cycle.
- LEN: rx_ready=1. Each accepted byte shifts into len, little-endian: byte k goes to bits [8k+7:8k]. On the 4th byte, evaluate the complete value:
  - len==0 -> DONE, with done pulsed the next cycle.
  - len>MAX_WORDS -> ERR, err=1.
  - otherwise -> DATA.
- DATA: rx_ready=1. Bytes assemble little-endian into a 32-bit word. On the 4th byte:
  - Register wr_en=1, wr_addr=BASE_ADDR+words_loaded, wr_data=assembled word, valid in the following cycle (1-cycle latency from the last byte to the write).
  - words_loaded increments together with the write.
  - When the increment makes words_loaded==len: -> DONE, done=1 in the cycle after that write.
- byte_cnt is 2 bits, wraps 3->0, and is reset on entry to LEN and to DATA.
- core_stall=1 in LEN and DATA, and for the cycle that carries the final write. It is 0 in IDLE, DONE and ERR.
- Store arbitration:
  - When not busy and no loader write is pending: st_gnt=st_req (combinational). wr_en/wr_addr/wr_data pass st_req/st_addr/st_data through registered, 1-cycle latency.
  - While busy: st_gnt=0, and stores stall by protocol because core_stall=1.
  - A loader write always wins the port.
- A start pulse while busy is ignored; the load in progress continues.
- A reset during a load aborts it: partial memory contents stay as written, and the next start reloads from BASE_ADDR.
- rx_valid without rx_ready drops nothing; the upstream UART holds the byte.
- Width rules: len is 32 bits internally; only the comparison with MAX_WORDS uses all 32 bits. The address add is ADDR_W bits wide and never wraps, since MAX_WORDS+BASE_ADDR<=4068 is a static requirement checked by an elaboration assertion.

Decomposition:
- Shared package: the state enum (IDLE, LEN, DATA, DONE, ERR), IMEM_ADDR_W=12, IMEM_WORDS=4096, LOADER_BASE=4068.
- One sub-module: imem_byte_packer. It performs the byte-to-32-bit little-endian assembly, with a clear input and a word_valid pulse. The same unit serves both the LEN and DATA phases.

Test Plan:
- Load 2 words: start, then bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> writes (0,0x12345678) and (1,0xDEADBEEF), each one cycle after its 4th byte. Then done pulses once, words_loaded=2, core_stall falls.
- Count 0 (00 00 00 00) -> no wr_en, done pulses, err=0, words_loaded=0.
- Count 4069 (E5 0F 00 00) -> ERR, err=1, no writes, rx_ready=0 afterwards. A later start clears err.
- Core stores in IDLE: st_req with addr 0x005, data 0xCAFEF00D -> st_gnt=1 the same cycle, then wr_en with (5,0xCAFEF00D) the next cycle. During a load, st_req gets st_gnt=0.
- Gapped rx_valid (random idle cycles between bytes), plus a start pulse mid-load -> identical writes and one done pulse; the extra start has no effect.
- Assert rst low after 5 data bytes of a 3-word load -> all outputs 0 immediately. A fresh start then writes from address 0 with correct data.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_load_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_WORDS  = 4096;
  localparam int LOADER_BASE = 4068;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler shared by the length and data phases.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // The 4th byte completes the word combinationally so the consumer can act in the same cycle.
  assign word_valid = byte_valid && !clear && (byte_cnt == 2'd3);
  assign word       = {byte_data, low_bytes};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid && !clear) begin
      low_bytes <= {byte_data, low_bytes[23:8]};
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Loads a UART program image into instruction memory and arbitrates the imem
// write port between the loader and core stores.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4068
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  if (BASE_ADDR + MAX_WORDS > LOADER_BASE) begin : g_bad_window
    $error("imem_load_ctrl: BASE_ADDR+MAX_WORDS would overwrite the boot loader");
  end

  state_t          state, state_nx;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wl_inc;
  logic            ld_wr;
  logic            last_wr;
  logic            pk_clear;
  logic            byte_valid;
  logic            word_valid;
  logic [31:0]     word;
  logic            start_acc;
  logic            len_fire;
  logic            len_zero;
  logic            len_over;
  logic            ld_fire;
  logic            ld_last;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (byte_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  assign wl_inc     = words_loaded + 1'b1;
  assign byte_valid = rx_valid && rx_ready;
  assign busy       = (state == S_LEN) || (state == S_DATA);
  // The final loader write lands after the FSM has left DATA; keep the core frozen through it.
  assign core_stall = busy || ld_wr;
  assign st_gnt     = st_req && !busy && !ld_wr;

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    pk_clear  = 1'b0;
    start_acc = 1'b0;
    len_fire  = 1'b0;
    len_zero  = 1'b0;
    len_over  = 1'b0;
    ld_fire   = 1'b0;
    ld_last   = 1'b0;
    case (state)
      S_LEN: begin
        rx_ready = 1'b1;
        if (word_valid) begin
          len_fire = 1'b1;
          // Full 32-bit compare: a huge count must not alias to a small one.
          if (word == 32'd0) begin
            len_zero = 1'b1;
            state_nx = S_DONE;
          end else if (word > 32'(MAX_WORDS)) begin
            len_over = 1'b1;
            state_nx = S_ERR;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (word_valid) begin
          ld_fire = 1'b1;
          if (wl_inc == len) begin
            ld_last  = 1'b1;
            state_nx = S_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          start_acc = 1'b1;
          pk_clear  = 1'b1;
          state_nx  = S_LEN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      len          <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
      ld_wr        <= 1'b0;
      last_wr      <= 1'b0;
      done         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      state   <= state_nx;
      ld_wr   <= ld_fire;
      last_wr <= ld_last;
      done    <= len_zero || last_wr;
      wr_en   <= ld_fire || st_gnt;
      if (start_acc) begin
        err          <= 1'b0;
        words_loaded <= '0;
      end
      if (len_fire) begin
        len <= word[ADDR_W:0];
      end
      if (len_over) begin
        err <= 1'b1;
      end
      if (ld_fire) begin
        words_loaded <= wl_inc;
        wr_addr      <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
        wr_data      <= word;
      end else if (st_gnt) begin
        wr_addr <= st_addr;
        wr_data <= st_data;
      end
    end
  end

endmodule
